// File: rtl/irq_mode_arbiter.sv
// Interrupt request arbiter with per-line edge/level capture, three masking
// modes, fixed lowest-index-wins priority and a REQ/ACK handshake to the CPU.
// Once a line is presented it is held until it is acknowledged or loses
// eligibility; higher-priority arrivals never preempt it.
module irq_mode_arbiter #(
  parameter int NUM_IRQ = 16,
  parameter int NUM_IPR = 8,
  parameter int ID_W    = $clog2(NUM_IRQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic [NUM_IRQ-1:0] edge_sel,
  input  logic [1:0]         intm,
  input  logic               i_bit,
  input  logic [NUM_IPR-1:0] ipr_en,
  input  logic               irq_ack,
  output logic               irq_req,
  output logic [ID_W-1:0]    irq_id,
  output logic [NUM_IRQ-1:0] pending
);

  // First line index controlled by the IPR enables.
  localparam int IPR_BASE = NUM_IRQ - NUM_IPR;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_CLR  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               irq_req_q, irq_req_d;
  logic [ID_W-1:0]    irq_id_q, irq_id_d;

  logic [NUM_IRQ-1:0] pending_q, pending_d;
  logic [NUM_IRQ-1:0] prev_q;
  // Cleared by reset; edge detection is suppressed until one sample has been
  // taken, so a line already high when reset releases is not seen as an edge.
  logic               armed_q;

  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] ipr_gate;
  logic [NUM_IRQ-1:0] eligible;
  logic [NUM_IRQ-1:0] clr_mask;
  logic [NUM_IRQ-1:0] id_onehot;
  logic [ID_W-1:0]    winner_id;
  logic               any_eligible;
  logic               presented_eligible;
  logic               ack_taken;

  // ---------------------------------------------------------------------
  // Request capture
  // ---------------------------------------------------------------------
  assign rise = irq_in & ~prev_q & {NUM_IRQ{armed_q}};

  genvar gi;
  generate
    for (gi = 0; gi < NUM_IRQ; gi++) begin : g_line
      // Edge lines: a new rising edge wins over a same-cycle acknowledge clear.
      // Level lines simply track the input one cycle late.
      assign pending_d[gi] = edge_sel[gi]
                           ? (rise[gi] | (pending_q[gi] & ~clr_mask[gi]))
                           : irq_in[gi];

      // Mode-1 gate: upper lines use their IPR enable, lower lines the I bit.
      if (gi >= IPR_BASE) begin : g_ipr
        assign ipr_gate[gi] = ipr_en[gi-IPR_BASE];
      end else begin : g_ibit
        assign ipr_gate[gi] = ~i_bit;
      end
    end
  endgenerate

  // Input sampling: pending bits, previous-sample history and arming flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q <= '0;
      prev_q    <= '0;
      armed_q   <= 1'b0;
    end else begin
      pending_q <= pending_d;
      prev_q    <= irq_in;
      armed_q   <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Eligibility and priority
  // ---------------------------------------------------------------------
  // Masking is purely combinational so mode/mask changes act immediately.
  always_comb begin
    eligible = pending_q & {NUM_IRQ{~i_bit}};
    case (intm)
      2'd1:    eligible = pending_q & ipr_gate;
      2'd2:    eligible = pending_q;
      default: eligible = pending_q & {NUM_IRQ{~i_bit}};
    endcase
  end

  // Lowest-index eligible line wins; scan from the top so index 0 is last.
  always_comb begin
    winner_id = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        winner_id = ID_W'(i);
      end
    end
  end

  assign any_eligible       = |eligible;
  assign presented_eligible = eligible[irq_id_q];
  assign ack_taken          = (state_q == ST_REQ) && irq_ack;
  assign id_onehot          = {{(NUM_IRQ-1){1'b0}}, 1'b1} << irq_id_q;

  // ---------------------------------------------------------------------
  // Handshake FSM
  // ---------------------------------------------------------------------
  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      irq_req_q <= 1'b0;
      irq_id_q  <= '0;
    end else begin
      state_q   <= state_d;
      irq_req_q <= irq_req_d;
      irq_id_q  <= irq_id_d;
    end
  end

  // Next-state: acknowledge outranks a simultaneous loss of eligibility.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (any_eligible) begin
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (irq_ack) begin
          state_d = ST_CLR;
        end else if (!presented_eligible) begin
          state_d = ST_IDLE;
        end
      end
      ST_CLR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs: request/id for the next cycle and the acknowledge clear mask.
  always_comb begin
    irq_req_d = 1'b0;
    irq_id_d  = irq_id_q;
    clr_mask  = '0;
    case (state_q)
      ST_IDLE: begin
        if (any_eligible) begin
          irq_req_d = 1'b1;
          irq_id_d  = winner_id;
        end
      end
      ST_REQ: begin
        if (ack_taken) begin
          clr_mask  = id_onehot & edge_sel;
          irq_req_d = 1'b0;
        end else if (!presented_eligible) begin
          irq_req_d = 1'b0;
        end else begin
          irq_req_d = 1'b1;
        end
      end
      default: begin
        irq_req_d = 1'b0;
      end
    endcase
  end

  assign irq_req = irq_req_q;
  assign irq_id  = irq_id_q;
  assign pending = pending_q;

endmodule

// File: tb/tb_irq_mode_arbiter.sv
// Self-checking bench for irq_mode_arbiter: directed scenarios with constant
// expectations plus a randomized run checked against a behavioural model.
module tb_irq_mode_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] irq_in = '0;
  logic [15:0] edge_sel = 16'hFF7F;
  logic [1:0]  intm = 2'd0;
  logic        i_bit = 1'b0;
  logic [7:0]  ipr_en = '0;
  logic        irq_ack = 1'b0;
  logic        irq_req;
  logic [3:0]  irq_id;
  logic [15:0] pending;

  int n_chk  = 0;
  int n_fail = 0;

  irq_mode_arbiter #(.NUM_IRQ(16), .NUM_IPR(8)) dut (
    .clk(clk), .rst(rst), .irq_in(irq_in), .edge_sel(edge_sel),
    .intm(intm), .i_bit(i_bit), .ipr_en(ipr_en), .irq_ack(irq_ack),
    .irq_req(irq_req), .irq_id(irq_id), .pending(pending)
  );

  always #5 clk = ~clk;

  // Behavioural model: handshake phase 0=idle, 1=presenting, 2=gap.
  logic [15:0] m_pend, m_prev, n_pend;
  bit          m_armed;
  int          m_phase, n_phase;
  logic        m_req, n_req;
  logic [3:0]  m_id, n_id;

  function automatic logic [15:0] allowed(input logic [15:0] p, input logic [1:0] mode,
                                          input logic ib, input logic [7:0] en);
    logic [15:0] r;
    for (int n = 0; n < 16; n++) begin
      if (mode == 2'd2)                r[n] = p[n];
      else if (mode == 2'd1 && n >= 8) r[n] = p[n] & en[n-8];
      else                             r[n] = p[n] & ~ib;
    end
    return r;
  endfunction

  task automatic model_reset();
    m_pend = '0; m_prev = '0; m_armed = 0; m_phase = 0; m_req = 0; m_id = '0;
  endtask

  task automatic model_calc();
    logic [15:0] el;
    logic [15:0] cleared;
    el = allowed(m_pend, intm, i_bit, ipr_en);
    cleared = '0;
    n_phase = m_phase; n_req = 1'b0; n_id = m_id;
    if (m_phase == 0) begin
      if (el != 0) begin
        for (int n = 15; n >= 0; n--) if (el[n]) n_id = 4'(n);
        n_req = 1'b1; n_phase = 1;
      end
    end else if (m_phase == 1) begin
      if (irq_ack) begin
        cleared[m_id] = 1'b1; n_phase = 2;
      end else if (!el[m_id]) begin
        n_phase = 0;
      end else begin
        n_req = 1'b1;
      end
    end else begin
      n_phase = 0;
    end
    for (int n = 0; n < 16; n++) begin
      if (edge_sel[n])
        n_pend[n] = (irq_in[n] && !m_prev[n] && m_armed) || (m_pend[n] && !cleared[n]);
      else
        n_pend[n] = irq_in[n];
    end
  endtask

  task automatic model_commit();
    m_pend = n_pend; m_prev = irq_in; m_armed = 1; m_phase = n_phase;
    m_req = n_req; m_id = n_id;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    model_calc();
    cyc();
    model_commit();
  endtask

  task automatic do_reset();
    irq_ack = 1'b0;
    rst = 1'b1;
    model_reset();
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    irq_in = '0;
    do_reset();
    n_chk++;
    if (irq_req !== 1'b0 || irq_id !== 4'd0 || pending !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_state: req=%b id=%0d pend=%h expected 0/0/0000", irq_req, irq_id, pending);
    end
    $display("test_reset: done");
  endtask

  task automatic test_edge_basic();
    intm = 2'd0; i_bit = 1'b0; irq_in = '0;
    do_reset(); tick();
    irq_in[3] = 1'b1; tick(); irq_in[3] = 1'b0;
    n_chk++;
    if (pending[3] !== 1'b1 || irq_req !== 1'b0) begin
      n_fail++; $display("FAIL edge_pending: pend3=%b req=%b expected 1/0", pending[3], irq_req);
    end
    tick();
    n_chk++;
    if (irq_req !== 1'b1 || irq_id !== 4'd3) begin
      n_fail++; $display("FAIL edge_request: req=%b id=%0d expected 1/3", irq_req, irq_id);
    end
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    n_chk++;
    if (pending[3] !== 1'b0 || irq_req !== 1'b0) begin
      n_fail++; $display("FAIL edge_ack_clear: pend3=%b req=%b expected 0/0", pending[3], irq_req);
    end
    tick(); tick();
    n_chk++;
    if (irq_req !== 1'b0) begin
      n_fail++; $display("FAIL edge_after_gap: req=%b expected 0", irq_req);
    end
    $display("test_edge_basic: done");
  endtask

  task automatic test_priority();
    intm = 2'd0; i_bit = 1'b0; irq_in = '0;
    do_reset(); tick();
    irq_in = 16'h1020; tick(); irq_in = '0; tick();
    n_chk++;
    if (irq_req !== 1'b1 || irq_id !== 4'd5) begin
      n_fail++; $display("FAIL prio_first: req=%b id=%0d expected 1/5", irq_req, irq_id);
    end
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    tick(); tick();
    n_chk++;
    if (irq_req !== 1'b1 || irq_id !== 4'd12) begin
      n_fail++; $display("FAIL prio_second: req=%b id=%0d expected 1/12", irq_req, irq_id);
    end
    $display("test_priority: done");
  endtask

  task automatic test_ipr_mode();
    intm = 2'd1; i_bit = 1'b1; ipr_en = 8'h10; irq_in = '0;
    do_reset(); tick();
    irq_in = 16'h1004; tick(); irq_in = '0; tick();
    n_chk++;
    if (irq_req !== 1'b1 || irq_id !== 4'd12 || pending[2] !== 1'b1) begin
      n_fail++; $display("FAIL ipr_present: req=%b id=%0d pend2=%b expected 1/12/1", irq_req, irq_id, pending[2]);
    end
    ipr_en = 8'h00; tick();
    n_chk++;
    if (irq_req !== 1'b0) begin
      n_fail++; $display("FAIL ipr_withdraw: req=%b expected 0", irq_req);
    end
    tick(); tick();
    n_chk++;
    if (irq_req !== 1'b0 || pending !== 16'h1004) begin
      n_fail++; $display("FAIL ipr_blocked: req=%b pend=%h expected 0/1004", irq_req, pending);
    end
    intm = 2'd0; i_bit = 1'b0; ipr_en = '0;
    $display("test_ipr_mode: done");
  endtask

  task automatic test_level_ack();
    intm = 2'd0; i_bit = 1'b0; irq_in = '0;
    do_reset(); tick();
    irq_in[7] = 1'b1; tick(); tick();
    n_chk++;
    if (irq_req !== 1'b1 || irq_id !== 4'd7) begin
      n_fail++; $display("FAIL level_request: req=%b id=%0d expected 1/7", irq_req, irq_id);
    end
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    n_chk++;
    if (pending[7] !== 1'b1 || irq_req !== 1'b0) begin
      n_fail++; $display("FAIL level_not_cleared: pend7=%b req=%b expected 1/0", pending[7], irq_req);
    end
    tick(); tick();
    n_chk++;
    if (irq_req !== 1'b1 || irq_id !== 4'd7) begin
      n_fail++; $display("FAIL level_reassert: req=%b id=%0d expected 1/7", irq_req, irq_id);
    end
    irq_in[7] = 1'b0;
    $display("test_level_ack: done");
  endtask

  task automatic test_no_preempt();
    intm = 2'd0; i_bit = 1'b0; irq_in = '0;
    do_reset(); tick();
    irq_in[9] = 1'b1; tick(); irq_in[9] = 1'b0; tick();
    irq_in[1] = 1'b1; tick(); irq_in[1] = 1'b0; tick(); tick();
    n_chk++;
    if (irq_req !== 1'b1 || irq_id !== 4'd9 || pending[1] !== 1'b1) begin
      n_fail++; $display("FAIL no_preempt: req=%b id=%0d pend1=%b expected 1/9/1", irq_req, irq_id, pending[1]);
    end
    irq_ack = 1'b1; tick(); irq_ack = 1'b0; tick(); tick();
    n_chk++;
    if (irq_req !== 1'b1 || irq_id !== 4'd1) begin
      n_fail++; $display("FAIL next_after_ack: req=%b id=%0d expected 1/1", irq_req, irq_id);
    end
    $display("test_no_preempt: done");
  endtask

  task automatic test_async_reset();
    intm = 2'd0; i_bit = 1'b0; irq_in = '0;
    do_reset(); tick();
    irq_in[3] = 1'b1; tick(); tick();
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    n_chk++;
    if (irq_req !== 1'b0 || pending !== 16'h0) begin
      n_fail++; $display("FAIL async_reset: req=%b pend=%h expected 0/0000", irq_req, pending);
    end
    cyc(); cyc();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_chk++;
      if (irq_req !== 1'b0 || pending[3] !== 1'b0) begin
        n_fail++; $display("FAIL held_high_no_edge: cyc=%0d req=%b pend3=%b expected 0/0", k, irq_req, pending[3]);
      end
    end
    irq_in[3] = 1'b0; tick();
    irq_in[3] = 1'b1; tick();
    n_chk++;
    if (pending[3] !== 1'b1) begin
      n_fail++; $display("FAIL toggle_edge: pend3=%b expected 1", pending[3]);
    end
    tick();
    n_chk++;
    if (irq_req !== 1'b1 || irq_id !== 4'd3) begin
      n_fail++; $display("FAIL toggle_request: req=%b id=%0d expected 1/3", irq_req, irq_id);
    end
    irq_in = '0;
    $display("test_async_reset: done");
  endtask

  task automatic test_level_through_reset();
    intm = 2'd0; i_bit = 1'b0;
    irq_in = 16'h0080;
    do_reset(); tick();
    n_chk++;
    if (pending[7] !== 1'b1 || irq_req !== 1'b0) begin
      n_fail++; $display("FAIL level_held_pending: pend7=%b req=%b expected 1/0", pending[7], irq_req);
    end
    tick();
    n_chk++;
    if (irq_req !== 1'b1 || irq_id !== 4'd7) begin
      n_fail++; $display("FAIL level_held_request: req=%b id=%0d expected 1/7", irq_req, irq_id);
    end
    irq_in = '0;
    $display("test_level_through_reset: done");
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    irq_in = '0;
    edge_sel = 16'($urandom);
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      irq_in  = 16'($urandom & $urandom & $urandom);
      irq_ack = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 15) == 0) intm = 2'($urandom);
      i_bit  = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 7) == 0) ipr_en = 8'($urandom);
      if (c == 1500) edge_sel = 16'($urandom);
      tick();
      n_chk++;
      if (irq_req !== m_req) begin
        n_fail++; errs++;
        $display("FAIL rand_req: cyc=%0d req=%b expected %b", c, irq_req, m_req);
      end
      n_chk++;
      if (m_req && irq_id !== m_id) begin
        n_fail++; errs++;
        $display("FAIL rand_id: cyc=%0d id=%0d expected %0d", c, irq_id, m_id);
      end
      n_chk++;
      if (pending !== m_pend) begin
        n_fail++; errs++;
        $display("FAIL rand_pending: cyc=%0d pend=%h expected %h", c, pending, m_pend);
      end
      if (errs > 20) break;
    end
    irq_ack = 1'b0; irq_in = '0;
    $display("test_random: done, %0d errors", errs);
  endtask

  initial begin
    model_reset();
    test_reset();
    test_edge_basic();
    test_priority();
    test_ipr_mode();
    test_level_ack();
    test_no_preempt();
    test_async_reset();
    test_level_through_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/irq_mode_arbiter.md
IRQ_MODE_ARBITER -- requirements
Module: irq_mode_arbiter

Interface
REQ-001 Parameter NUM_IRQ, default 16: number of interrupt request lines; line 0 is highest priority.
REQ-002 Parameter NUM_IPR, default 8: number of upper lines gated by IPR enable; 1 <= NUM_IPR <= NUM_IRQ.
REQ-003 Parameter ID_W, default $clog2(NUM_IRQ): width of the interrupt identifier.
REQ-004 Port clk  input  1: single clock; all state updates on rising edge.
REQ-005 Port rst  input  1: reset, asynchronous, active-high.
REQ-006 Port irq_in  input  NUM_IRQ: raw request lines.
REQ-007 Port edge_sel  input  NUM_IRQ: per line; 1 = rising-edge latched, 0 = level.
REQ-008 Port intm  input  2: mask mode select.
REQ-009 Port i_bit  input  1: global mask bit; 1 blocks I-gated lines.
REQ-010 Port ipr_en  input  NUM_IPR: bit k enables line NUM_IRQ-NUM_IPR+k.
REQ-011 Port irq_ack  input  1: CPU acknowledge of the presented request.
REQ-012 Port irq_req  output  1: request to CPU, registered.
REQ-013 Port irq_id  output  ID_W: index of the presented line, registered.
REQ-014 Port pending  output  NUM_IRQ: current pending register.

Function
REQ-015 Edge line: pending[n] SHALL set on the cycle after irq_in[n] is sampled 1 while its previous sample was 0.
REQ-016 Level line: pending[n] SHALL equal irq_in[n] registered one cycle.
REQ-017 Eligibility, intm=0: eligible[n] = pending[n] & ~i_bit for all lines.
REQ-018 Eligibility, intm=1: upper NUM_IPR lines use pending & ipr_en; lower lines use pending & ~i_bit.
REQ-019 Eligibility, intm=2: eligible = pending (no masking); intm=3 SHALL behave as intm=0.
REQ-020 Winner SHALL be the lowest-index eligible line.
REQ-021 FSM states: IDLE, REQ, CLR.
REQ-022 IDLE: if any line is eligible, latch the winner into irq_id, set irq_req=1 and go to REQ; otherwise irq_req=0.
REQ-023 REQ: irq_req=1; irq_id SHALL stay stable and SHALL NOT be preempted by higher-priority lines.
REQ-024 REQ with irq_ack=1: clear pending[irq_id] if it is an edge line (level lines are not cleared), set irq_req=0, go to CLR.
REQ-025 REQ with latched line no longer eligible and irq_ack=0: withdraw, set irq_req=0, go to IDLE.
REQ-026 REQ with simultaneous ack and loss of eligibility: ack SHALL take precedence.
REQ-027 CLR: one-cycle gap, then return to IDLE unconditionally; irq_req=0.
REQ-028 A new edge on a line in the same cycle its pending bit is cleared by ack: set SHALL win.
REQ-029 irq_ack in IDLE or CLR SHALL be ignored.
REQ-030 Latency: edge sampled at cycle N -> pending at N+1 -> irq_req=1 at N+2.
REQ-031 Mode, mask and ipr_en changes SHALL take effect on eligibility in the same cycle; no registering.

Reset
REQ-032 On rst=1, asynchronously: pending=0, previous-sample register=0, state=IDLE, irq_req=0, irq_id=0.
REQ-033 rst asserted mid-REQ SHALL drop irq_req immediately and discard all pending.
REQ-034 After rst deasserts, a line held high SHALL NOT be treated as an edge until its first 0->1 transition; a level line held high SHALL request.

Verification
REQ-035 NUM_IRQ=16, NUM_IPR=8, intm=0, i_bit=0, edge line 3 pulsed at cycle N -> pending[3]=1 at N+1, irq_req=1 with irq_id=3 at N+2; ack -> pending[3]=0, 1-cycle gap, irq_req=0.
REQ-036 Lines 5 and 12 pending together, intm=0 -> irq_id=5 first; after ack and CLR -> irq_id=12.
REQ-037 intm=1, i_bit=1, line 12 pending, ipr_en[4]=1 -> irq_id=12 presented; line 2 pending -> blocked; ipr_en[4]=0 during REQ -> irq_req=0 the next cycle (withdraw).
REQ-038 Level line 7 held high, ack given -> pending[7] stays 1; irq_req reasserts with irq_id=7 two cycles after the ack.
REQ-039 Line 9 presented in REQ; line 1 becomes eligible -> irq_id remains 9 until ack.
REQ-040 rst pulsed while irq_req=1 -> irq_req=0 and pending=0 without a clock edge; edge line held high through reset -> no request until it toggles.
